// File: rtl/inst_issue_queue.sv
// Dual-in/dual-out instruction buffer between fetch and dual-issue launch.
// Ports: fetch pair in (valids, pre_to_ibus, allowin_o), launch flags in,
//   head pair out (valids, to_id_obus), count_o, err_o.
//   Define IQ_FLAG_CHECK_EN to enable sticky protocol checking on err_o.
module inst_issue_queue #(
  parameter int DEPTH   = 8,
  parameter int ENTRY_W = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      line1_pre_to_now_valid_i,
  input  logic                      line2_pre_to_now_valid_i,
  input  logic [2*ENTRY_W-1:0]      pre_to_ibus,
  output logic                      allowin_o,
  input  logic                      now_allowin_i,
  input  logic                      double_valid_inst_lunch_flag_i,
  input  logic                      single_valid_inst_lunch_flag_i,
  input  logic                      zero_valid_inst_lunch_flag_i,
  input  logic                      branch_flush_i,
  input  logic                      excep_flush_i,
  output logic                      line1_now_valid_o,
  output logic                      line2_now_valid_o,
  output logic [2*ENTRY_W-1:0]      to_id_obus,
  output logic [$clog2(DEPTH):0]    count_o,
  output logic                      err_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ENTRY_W-1:0] ram [DEPTH];
  logic [PW-1:0]      rd_ptr;
  logic [PW-1:0]      wr_ptr;
  logic [CW-1:0]      count;

  logic               v1;
  logic               v2;
  logic [ENTRY_W-1:0] slot1;
  logic [ENTRY_W-1:0] slot2;
  logic               allow;
  logic               push_ok;
  logic [CW-1:0]      push_n;
  logic [CW-1:0]      pop_req;
  logic [CW-1:0]      pop_n;
  logic [PW-1:0]      wr_ptr2;
  logic [PW-1:0]      rd_ptr1;
  logic [PW-1:0]      rd_adv;

  assign v1    = line1_pre_to_now_valid_i;
  assign v2    = line2_pre_to_now_valid_i;
  assign slot1 = pre_to_ibus[ENTRY_W-1:0];
  assign slot2 = pre_to_ibus[2*ENTRY_W-1:ENTRY_W];

  // Credit comes from the registered count only, so a same-cycle
  // pop never lets a pair in early.
  assign allow   = (CW'(DEPTH) - count) >= CW'(2);
  assign push_ok = allow & ~branch_flush_i & ~excep_flush_i;

  always_comb begin
    push_n = '0;
    if (allow) begin
      push_n = CW'(v1) + CW'(v2);
    end
  end

  // Flags may overlap; the widest pop wins.
  always_comb begin
    pop_req = '0;
    if (now_allowin_i) begin
      if (double_valid_inst_lunch_flag_i) begin
        pop_req = CW'(2);
      end else if (single_valid_inst_lunch_flag_i) begin
        pop_req = CW'(1);
      end else begin
        pop_req = '0;
      end
    end
  end

  assign pop_n = (pop_req > count) ? count : pop_req;

  // Slot2 packs down onto wr_ptr when slot1 is empty.
  assign wr_ptr2 = wr_ptr + PW'(v1);
  assign rd_ptr1 = rd_ptr + PW'(1);
  assign rd_adv  = rd_ptr + PW'(pop_n);

  always_ff @(posedge clk) begin
    if (push_ok && v1) begin
      ram[wr_ptr] <= slot1;
    end
    if (push_ok && v2) begin
      ram[wr_ptr2] <= slot2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (excep_flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (branch_flush_i) begin
      // Issued group retires, everything younger is dropped.
      rd_ptr <= rd_adv;
      wr_ptr <= rd_adv;
      count  <= '0;
    end else begin
      rd_ptr <= rd_adv;
      wr_ptr <= wr_ptr + PW'(push_n);
      count  <= count + push_n - pop_n;
    end
  end

  always_comb begin
    line1_now_valid_o = (count >= CW'(1));
    line2_now_valid_o = (count >= CW'(2));
    to_id_obus        = '0;
    if (line1_now_valid_o) begin
      to_id_obus[ENTRY_W-1:0] = ram[rd_ptr];
    end
    if (line2_now_valid_o) begin
      to_id_obus[2*ENTRY_W-1:ENTRY_W] = ram[rd_ptr1];
    end
  end

  assign allowin_o = allow;
  assign count_o   = count;

`ifdef IQ_FLAG_CHECK_EN
  logic       err;
  logic [1:0] nflags;
  logic       bad;

  assign nflags = 2'(double_valid_inst_lunch_flag_i)
                + 2'(single_valid_inst_lunch_flag_i)
                + 2'(zero_valid_inst_lunch_flag_i);

  always_comb begin
    bad = 1'b0;
    if (now_allowin_i && nflags > 2'd1) begin
      bad = 1'b1;
    end
    if (now_allowin_i && double_valid_inst_lunch_flag_i
        && count < CW'(2)) begin
      bad = 1'b1;
    end
    if (now_allowin_i && single_valid_inst_lunch_flag_i
        && count < CW'(1)) begin
      bad = 1'b1;
    end
    if (v2 && !v1) begin
      bad = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (bad) begin
      err <= 1'b1;
    end
  end

  assign err_o = err;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_inst_issue_queue.sv
// Directed bench for inst_issue_queue.
// Scenario tasks with inline checks, one summary line at the end.
module tb_inst_issue_queue;

  logic         clk;
  logic         rst_n;
  logic         v1;
  logic         v2;
  logic [127:0] ibus;
  logic         allowin;
  logic         now;
  logic         dbl;
  logic         sgl;
  logic         zro;
  logic         brf;
  logic         exf;
  logic         l1v;
  logic         l2v;
  logic [127:0] obus;
  logic [3:0]   count;
  logic         err;

  int errors = 0;
  int checks = 0;

`ifdef IQ_FLAG_CHECK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  inst_issue_queue dut (
    .clk                            (clk),
    .rst_n                          (rst_n),
    .line1_pre_to_now_valid_i       (v1),
    .line2_pre_to_now_valid_i       (v2),
    .pre_to_ibus                    (ibus),
    .allowin_o                      (allowin),
    .now_allowin_i                  (now),
    .double_valid_inst_lunch_flag_i (dbl),
    .single_valid_inst_lunch_flag_i (sgl),
    .zero_valid_inst_lunch_flag_i   (zro),
    .branch_flush_i                 (brf),
    .excep_flush_i                  (exf),
    .line1_now_valid_o              (l1v),
    .line2_now_valid_o              (l2v),
    .to_id_obus                     (obus),
    .count_o                        (count),
    .err_o                          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] mk(input int n);
    return {32'h8000_0000 + 32'(n * 4), 32'h0000_1300 + 32'(n)};
  endfunction

  task automatic idle();
    v1 = 0; v2 = 0; ibus = '0; now = 0;
    dbl = 0; sgl = 0; zro = 0; brf = 0; exf = 0;
  endtask

  // Push slots (a valid if pa, b valid if pb) and pop request,
  // then advance one clock and sample 1ns later.
  task automatic cyc(input logic pa, input logic pb,
                     input int a, input int b,
                     input logic n, input logic d,
                     input logic s, input logic bf,
                     input logic ef);
    v1 = pa; v2 = pb;
    ibus = {mk(b), mk(a)};
    now = n; dbl = d; sgl = s; brf = bf; exf = ef;
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    #3;
    checks++; if (count !== 4'd0) begin $display("FAIL reset_count got=%0d exp=0", count); errors++; end
    checks++; if (l1v !== 1'b0 || l2v !== 1'b0) begin $display("FAIL reset_valid got=%b%b exp=00", l1v, l2v); errors++; end
    checks++; if (obus !== 128'd0) begin $display("FAIL reset_obus got=%h exp=0", obus); errors++; end
    checks++; if (allowin !== 1'b1) begin $display("FAIL reset_allowin got=%b exp=1", allowin); errors++; end
    checks++; if (err !== 1'b0) begin $display("FAIL reset_err got=%b exp=0", err); errors++; end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_push_pair();
    cyc(1, 1, 1, 2, 0, 0, 0, 0, 0);
    checks++; if (count !== 4'd2) begin $display("FAIL pair_count got=%0d exp=2", count); errors++; end
    checks++; if (l1v !== 1'b1 || l2v !== 1'b1) begin $display("FAIL pair_valid got=%b%b exp=11", l1v, l2v); errors++; end
    checks++; if (obus !== {mk(2), mk(1)}) begin $display("FAIL pair_data got=%h exp=%h", obus, {mk(2), mk(1)}); errors++; end
  endtask

  task automatic test_push_pop_same_cycle();
    cyc(1, 0, 3, 0, 0, 0, 0, 0, 0);
    checks++; if (count !== 4'd3) begin $display("FAIL single_push_count got=%0d exp=3", count); errors++; end
    // double requested but launch stalled: nothing retires
    cyc(0, 0, 0, 0, 0, 1, 0, 0, 0);
    checks++; if (count !== 4'd3) begin $display("FAIL stall_count got=%0d exp=3", count); errors++; end
    cyc(1, 1, 4, 5, 1, 1, 0, 0, 0);
    checks++; if (count !== 4'd3) begin $display("FAIL pushpop_count got=%0d exp=3", count); errors++; end
    checks++; if (obus !== {mk(4), mk(3)}) begin $display("FAIL pushpop_data got=%h exp=%h", obus, {mk(4), mk(3)}); errors++; end
    cyc(0, 0, 0, 0, 1, 1, 0, 0, 0);
    checks++; if (count !== 4'd1 || l2v !== 1'b0) begin $display("FAIL tail_count got=%0d/%b exp=1/0", count, l2v); errors++; end
    checks++; if (obus !== {64'd0, mk(5)}) begin $display("FAIL tail_data got=%h exp=%h", obus, {64'd0, mk(5)}); errors++; end
    cyc(0, 0, 0, 0, 1, 0, 1, 0, 0);
    checks++; if (count !== 4'd0 || l1v !== 1'b0) begin $display("FAIL empty_count got=%0d/%b exp=0/0", count, l1v); errors++; end
  endtask

  task automatic test_fill_wrap();
    for (int i = 0; i < 4; i++) begin
      cyc(1, 1, 10 + 2 * i, 11 + 2 * i, 0, 0, 0, 0, 0);
      if (i == 2) begin
        checks++; if (allowin !== 1'b1) begin $display("FAIL fill6_allowin got=%b exp=1", allowin); errors++; end
      end
    end
    checks++; if (count !== 4'd8) begin $display("FAIL full_count got=%0d exp=8", count); errors++; end
    checks++; if (allowin !== 1'b0) begin $display("FAIL full_allowin got=%b exp=0", allowin); errors++; end
    cyc(1, 1, 20, 21, 0, 0, 0, 0, 0);
    checks++; if (count !== 4'd8) begin $display("FAIL overflow_count got=%0d exp=8", count); errors++; end
    checks++; if (obus[63:0] !== mk(10)) begin $display("FAIL overflow_head got=%h exp=%h", obus[63:0], mk(10)); errors++; end
    cyc(0, 0, 0, 0, 1, 0, 1, 0, 0);
    checks++; if (count !== 4'd7 || allowin !== 1'b0) begin $display("FAIL seven_state got=%0d/%b exp=7/0", count, allowin); errors++; end
    checks++; if (obus !== {mk(12), mk(11)}) begin $display("FAIL seven_data got=%h exp=%h", obus, {mk(12), mk(11)}); errors++; end
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 1, 1, 0, 0, 0);
      checks++; if (count !== 4'(5 - 2 * i)) begin $display("FAIL drain_count%0d got=%0d exp=%0d", i, count, 5 - 2 * i); errors++; end
      checks++; if (obus[63:0] !== mk(13 + 2 * i)) begin $display("FAIL drain_head%0d got=%h exp=%h", i, obus[63:0], mk(13 + 2 * i)); errors++; end
    end
    checks++; if (l2v !== 1'b0 || obus[127:64] !== 64'd0) begin $display("FAIL drain_last got=%b/%h exp=0/0", l2v, obus[127:64]); errors++; end
    cyc(0, 0, 0, 0, 1, 0, 1, 0, 0);
    checks++; if (count !== 4'd0) begin $display("FAIL drained_count got=%0d exp=0", count); errors++; end
  endtask

  task automatic test_branch_flush();
    cyc(1, 1, 30, 31, 0, 0, 0, 0, 0);
    cyc(1, 1, 32, 33, 0, 0, 0, 0, 0);
    checks++; if (count !== 4'd4) begin $display("FAIL br_setup got=%0d exp=4", count); errors++; end
    cyc(1, 1, 34, 35, 1, 0, 1, 1, 0);
    checks++; if (count !== 4'd0) begin $display("FAIL br_count got=%0d exp=0", count); errors++; end
    checks++; if (l1v !== 1'b0 || l2v !== 1'b0) begin $display("FAIL br_valid got=%b%b exp=00", l1v, l2v); errors++; end
    cyc(1, 1, 36, 37, 0, 0, 0, 0, 0);
    checks++; if (obus !== {mk(37), mk(36)}) begin $display("FAIL br_refill got=%h exp=%h", obus, {mk(37), mk(36)}); errors++; end
    cyc(0, 0, 0, 0, 1, 1, 0, 0, 0);
  endtask

  task automatic test_excep_flush();
    cyc(1, 1, 40, 41, 0, 0, 0, 0, 0);
    cyc(1, 1, 42, 43, 0, 0, 0, 0, 0);
    cyc(1, 0, 44, 0, 0, 0, 0, 0, 0);
    checks++; if (count !== 4'd5) begin $display("FAIL ex_setup got=%0d exp=5", count); errors++; end
    cyc(1, 1, 45, 46, 1, 1, 0, 0, 1);
    checks++; if (count !== 4'd0 || l1v !== 1'b0) begin $display("FAIL ex_count got=%0d/%b exp=0/0", count, l1v); errors++; end
    checks++; if (dut.rd_ptr !== 3'd0 || dut.wr_ptr !== 3'd0) begin $display("FAIL ex_ptrs got=%0d/%0d exp=0/0", dut.rd_ptr, dut.wr_ptr); errors++; end
    cyc(1, 1, 47, 48, 0, 0, 0, 0, 0);
    checks++; if (dut.ram[0] !== mk(47) || obus[63:0] !== mk(47)) begin $display("FAIL ex_entry0 got=%h exp=%h", dut.ram[0], mk(47)); errors++; end
    cyc(0, 0, 0, 0, 1, 1, 0, 0, 0);
  endtask

  task automatic test_flags_and_err();
    cyc(1, 1, 50, 51, 0, 0, 0, 0, 0);
    cyc(1, 0, 52, 0, 0, 0, 0, 0, 0);
    checks++; if (err !== 1'b0) begin $display("FAIL err_clean got=%b exp=0", err); errors++; end
    // double and single together: double wins
    cyc(0, 0, 0, 0, 1, 1, 1, 0, 0);
    checks++; if (count !== 4'd1) begin $display("FAIL prio_count got=%0d exp=1", count); errors++; end
    checks++; if (obus[63:0] !== mk(52)) begin $display("FAIL prio_head got=%h exp=%h", obus[63:0], mk(52)); errors++; end
    checks++; if (err !== ERR_EXP) begin $display("FAIL prio_err got=%b exp=%b", err, ERR_EXP); errors++; end
    // double on a single entry clamps to one pop
    cyc(0, 0, 0, 0, 1, 1, 0, 0, 0);
    checks++; if (count !== 4'd0) begin $display("FAIL clamp_count got=%0d exp=0", count); errors++; end
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (err !== ERR_EXP) begin $display("FAIL err_sticky got=%b exp=%b", err, ERR_EXP); errors++; end
    // pops on empty are ignored
    cyc(0, 0, 0, 0, 1, 1, 0, 0, 0);
    checks++; if (count !== 4'd0) begin $display("FAIL empty_pop got=%0d exp=0", count); errors++; end
  endtask

  task automatic test_async_reset();
    cyc(1, 1, 60, 61, 0, 0, 0, 0, 0);
    rst_n = 0;
    #1;
    checks++; if (count !== 4'd0 || l1v !== 1'b0) begin $display("FAIL arst_count got=%0d/%b exp=0/0", count, l1v); errors++; end
    checks++; if (err !== 1'b0) begin $display("FAIL arst_err got=%b exp=0", err); errors++; end
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    rst_n = 1;
    idle();
    test_reset();
    test_push_pair();
    test_push_pop_same_cycle();
    test_fill_wrap();
    test_branch_flush();
    test_excep_flush();
    test_flags_and_err();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
